wb_arbiter_rr: RTL and testbench

- Round-robin arbiter sharing one Wishbone slave bus (36-bit address, 32-bit data, 4-bit select) between PORTS masters, e.g. soc_interface_wb plus a DMA or debug master.
- Grants are held for a whole bus cycle and released when the master drops CYC.
- A watchdog aborts strobes the slave never acknowledges and returns ERR to the stalled master.

---
 rtl/wb_arbiter_rr_pkg.sv | 19 +
 rtl/wb_arbiter_rr_select.sv | 32 +++
 rtl/wb_arbiter_rr.sv | 164 ++++++++++++++++
 tb/tb_wb_arbiter_rr.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_rr_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
// Arbiter states plus a width helper for the pointer and watchdog counter.
package wb_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_select.sv
// Combinational round-robin picker: first requester above the pointer wins,
// wrapping modulo PORTS, so the pointer itself has the lowest priority.
module arb_rr_select
  import wb_arbiter_rr_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int IDX_W = clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [PORTS-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int cand;
    cand   = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int off = 1; off <= PORTS; off++) begin
      cand = (int'(ptr) + off) % PORTS;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone slave between PORTS masters, with
// a watchdog that aborts unacknowledged strobes and returns ERR to the master.
module wb_arbiter_rr
  import wb_arbiter_rr_pkg::*;
#(
  parameter int PORTS      = 2,
  parameter int ADDR_WIDTH = 36,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024,
  localparam int SELECT_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*ADDR_WIDTH-1:0]   m_wb_adr_i,
  input  logic [PORTS*DATA_WIDTH-1:0]   m_wb_dat_i,
  output logic [DATA_WIDTH-1:0]         m_wb_dat_o,
  input  logic [PORTS-1:0]              m_wb_we_i,
  input  logic [PORTS*SELECT_WIDTH-1:0] m_wb_sel_i,
  input  logic [PORTS-1:0]              m_wb_stb_i,
  output logic [PORTS-1:0]              m_wb_ack_o,
  output logic [PORTS-1:0]              m_wb_err_o,
  input  logic [PORTS-1:0]              m_wb_cyc_i,
  output logic [ADDR_WIDTH-1:0]         s_wb_adr_o,
  input  logic [DATA_WIDTH-1:0]         s_wb_dat_i,
  output logic [DATA_WIDTH-1:0]         s_wb_dat_o,
  output logic                          s_wb_we_o,
  output logic [SELECT_WIDTH-1:0]       s_wb_sel_o,
  output logic                          s_wb_stb_o,
  input  logic                          s_wb_ack_i,
  input  logic                          s_wb_err_i,
  output logic                          s_wb_cyc_o,
  output logic [PORTS-1:0]              grant,
  output logic                          timeout
);

  localparam int IDX_W = clog2(PORTS);
  localparam int CNT_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t        state_reg;
  logic [PORTS-1:0]  grant_reg;
  logic [IDX_W-1:0]  ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [PORTS-1:0]  err_reg;
  logic              timeout_reg;

  logic [ADDR_WIDTH-1:0]   adr_arr [PORTS];
  logic [DATA_WIDTH-1:0]   dat_arr [PORTS];
  logic [SELECT_WIDTH-1:0] sel_arr [PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_unpack
      assign adr_arr[gi] = m_wb_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign dat_arr[gi] = m_wb_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sel_arr[gi] = m_wb_sel_i[gi*SELECT_WIDTH +: SELECT_WIDTH];
    end
  endgenerate

  logic [PORTS-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  arb_rr_select #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_select (
    .req    (m_wb_cyc_i),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // ptr_reg doubles as the granted index while a grant is held.
  logic sel_cyc, sel_stb, in_grant, live;
  assign sel_cyc  = m_wb_cyc_i[ptr_reg];
  assign sel_stb  = m_wb_stb_i[ptr_reg];
  assign in_grant = (state_reg == GRANT);
  assign live     = in_grant & sel_cyc & sel_stb;

  always_comb begin
    s_wb_adr_o = '0;
    s_wb_dat_o = '0;
    s_wb_sel_o = '0;
    s_wb_we_o  = 1'b0;
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    if (state_reg != IDLE) begin
      s_wb_adr_o = adr_arr[ptr_reg];
      s_wb_dat_o = dat_arr[ptr_reg];
      s_wb_sel_o = sel_arr[ptr_reg];
      s_wb_we_o  = m_wb_we_i[ptr_reg];
    end
    if (in_grant) begin
      s_wb_cyc_o = sel_cyc;
      s_wb_stb_o = sel_cyc & sel_stb;
    end
  end

  // Responses reach only the granted master, and only while it still strobes.
  assign m_wb_ack_o = (live && s_wb_ack_i) ? grant_reg : '0;
  assign m_wb_err_o = ((live && s_wb_err_i) ? grant_reg : '0) | err_reg;
  assign m_wb_dat_o = s_wb_dat_i;
  assign grant      = grant_reg;
  assign timeout    = timeout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      ptr_reg     <= IDX_W'(PORTS - 1);
      cnt_reg     <= '0;
      err_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      err_reg     <= '0;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (pick_valid) begin
            grant_reg <= pick_onehot;
            ptr_reg   <= pick_idx;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          if (!sel_cyc) begin
            grant_reg <= '0;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else if (TIMEOUT > 0 && s_wb_stb_o && !s_wb_ack_i && !s_wb_err_i) begin
            if (cnt_reg == CNT_LAST) begin
              err_reg     <= grant_reg;
              timeout_reg <= 1'b1;
              cnt_reg     <= '0;
              state_reg   <= ABORT;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
        ABORT: begin
          cnt_reg <= '0;
          if (!sel_cyc) begin
            grant_reg <= '0;
            state_reg <= IDLE;
          end else if (!sel_stb) begin
            state_reg <= GRANT;
          end
        end
        default: begin
          grant_reg <= '0;
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: scripted masters and slave, with per-master
// scoreboard queues popped whenever the slave acknowledges a strobe.
module tb_wb_arbiter_rr;

  localparam int PORTS = 2;
  localparam int AW    = 36;
  localparam int DW    = 32;
  localparam int SW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [PORTS*AW-1:0] m_wb_adr_i;
  logic [PORTS*DW-1:0] m_wb_dat_i;
  logic [DW-1:0]       m_wb_dat_o;
  logic [PORTS-1:0]    m_wb_we_i;
  logic [PORTS*SW-1:0] m_wb_sel_i;
  logic [PORTS-1:0]    m_wb_stb_i;
  logic [PORTS-1:0]    m_wb_ack_o;
  logic [PORTS-1:0]    m_wb_err_o;
  logic [PORTS-1:0]    m_wb_cyc_i;
  logic [AW-1:0]       s_wb_adr_o;
  logic [DW-1:0]       s_wb_dat_i;
  logic [DW-1:0]       s_wb_dat_o;
  logic                s_wb_we_o;
  logic [SW-1:0]       s_wb_sel_o;
  logic                s_wb_stb_o;
  logic                s_wb_ack_i;
  logic                s_wb_err_i;
  logic                s_wb_cyc_o;
  logic [PORTS-1:0]    grant;
  logic                timeout;

  always #5 clk = ~clk;

  wb_arbiter_rr #(
    .PORTS      (PORTS),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_wb_adr_i (m_wb_adr_i),
    .m_wb_dat_i (m_wb_dat_i),
    .m_wb_dat_o (m_wb_dat_o),
    .m_wb_we_i  (m_wb_we_i),
    .m_wb_sel_i (m_wb_sel_i),
    .m_wb_stb_i (m_wb_stb_i),
    .m_wb_ack_o (m_wb_ack_o),
    .m_wb_err_o (m_wb_err_o),
    .m_wb_cyc_i (m_wb_cyc_i),
    .s_wb_adr_o (s_wb_adr_o),
    .s_wb_dat_i (s_wb_dat_i),
    .s_wb_dat_o (s_wb_dat_o),
    .s_wb_we_o  (s_wb_we_o),
    .s_wb_sel_o (s_wb_sel_o),
    .s_wb_stb_o (s_wb_stb_o),
    .s_wb_ack_i (s_wb_ack_i),
    .s_wb_err_i (s_wb_err_i),
    .s_wb_cyc_o (s_wb_cyc_o),
    .grant      (grant),
    .timeout    (timeout)
  );

  // Master-side drive
  logic [AW-1:0] m_adr [PORTS];
  logic [DW-1:0] m_dat [PORTS];
  logic [SW-1:0] m_sel [PORTS];
  logic [1:0]    m_cyc, m_stb, m_we;

  assign m_wb_adr_i = {m_adr[1], m_adr[0]};
  assign m_wb_dat_i = {m_dat[1], m_dat[0]};
  assign m_wb_sel_i = {m_sel[1], m_sel[0]};
  assign m_wb_cyc_i = m_cyc;
  assign m_wb_stb_i = m_stb;
  assign m_wb_we_i  = m_we;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          we;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] glog[$];

  int checks = 0;
  int errors = 0;

  // Engine state
  int            act [PORTS];
  int            beat_idx [PORTS];
  int            nbeats [PORTS];
  int            cyc_rem [PORTS];
  logic [AW-1:0] base_adr [PORTS];
  logic [DW-1:0] base_dat [PORTS];
  logic [SW-1:0] base_sel [PORTS];
  logic          base_we [PORTS];
  int            auto_m = 0;
  int            slave_mode = 0;
  int            ack_delay = 1;
  int            wait_cnt = 0;
  logic [1:0]    samp_ack = '0;
  logic          samp_stb = 1'b0;
  logic          samp_sack = 1'b0;
  logic [1:0]    prev_grant = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int p, input exp_t e);
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, input logic we, input int ncyc, input int nb);
    base_adr[p] = adr;
    base_dat[p] = dat;
    base_sel[p] = sel;
    base_we[p]  = we;
    nbeats[p]   = nb;
    cyc_rem[p]  = ncyc;
  endtask

  task automatic master_step(input int p);
    exp_t e;
    if (act[p] != 0 && samp_ack[p]) begin
      beat_idx[p]++;
      if (beat_idx[p] == nbeats[p]) begin
        act[p] = 0;
        cyc_rem[p]--;
        base_adr[p] = base_adr[p] + 36'h100;
      end
    end else if (act[p] == 0 && cyc_rem[p] > 0) begin
      act[p] = 1;
      beat_idx[p] = 0;
      for (int b = 0; b < nbeats[p]; b++) begin
        e.adr = base_adr[p] + AW'(b);
        e.dat = base_dat[p] + DW'(b);
        e.sel = base_sel[p];
        e.we  = base_we[p];
        e.rd  = ~e.adr[DW-1:0];
        push_exp(p, e);
      end
    end
    m_cyc[p] = (act[p] != 0);
    m_stb[p] = (act[p] != 0);
    m_adr[p] = base_adr[p] + AW'(beat_idx[p]);
    m_dat[p] = base_dat[p] + DW'(beat_idx[p]);
    m_sel[p] = base_sel[p];
    m_we[p]  = base_we[p];
  endtask

  task automatic slave_step();
    if (slave_mode == 2) begin
      s_wb_ack_i = 1'b1;
    end else if (slave_mode == 1) begin
      s_wb_ack_i = 1'b0;
      wait_cnt = 0;
    end else if (samp_stb && !samp_sack) begin
      wait_cnt++;
      s_wb_ack_i = (wait_cnt >= ack_delay);
      s_wb_dat_i = ~s_wb_adr_o[DW-1:0];
    end else begin
      s_wb_ack_i = 1'b0;
      wait_cnt = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (!rst) begin
        if (auto_m != 0) begin
          master_step(0);
          master_step(1);
        end
        slave_step();
      end
    end
  end

  task automatic sb_compare();
    exp_t e;
    if (grant == 2'b01 && q0.size() > 0) e = q0.pop_front();
    else if (grant == 2'b10 && q1.size() > 0) e = q1.pop_front();
    else begin
      check("sb_unexpected_ack_grant", 64'(grant), 64'd0);
      return;
    end
    $display("ack grant=%b adr=%h dat=%h sel=%h we=%b", grant, s_wb_adr_o, s_wb_dat_o, s_wb_sel_o, s_wb_we_o);
    check("sb_adr", 64'(s_wb_adr_o), 64'(e.adr));
    check("sb_dat", 64'(s_wb_dat_o), 64'(e.dat));
    check("sb_sel", 64'(s_wb_sel_o), 64'(e.sel));
    check("sb_we", 64'(s_wb_we_o), 64'(e.we));
    check("sb_rdat", 64'(m_wb_dat_o), 64'(e.rd));
    check("sb_ack_route", 64'(m_wb_ack_o), 64'(grant));
    check("sb_no_err", 64'(m_wb_err_o), 64'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      samp_ack  = m_wb_ack_o;
      samp_stb  = s_wb_cyc_o && s_wb_stb_o;
      samp_sack = s_wb_ack_i;
      if (!rst) begin
        if (grant != 2'b00 && prev_grant == 2'b00) glog.push_back(grant);
        if (grant != 2'b00 && prev_grant != 2'b00) check("grant_hold", 64'(grant), 64'(prev_grant));
        if (s_wb_cyc_o && s_wb_stb_o && s_wb_ack_i) sb_compare();
      end
      prev_grant = grant;
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((act[0] != 0 || act[1] != 0 || cyc_rem[0] > 0 || cyc_rem[1] > 0 || grant != 2'b00)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] g, input int budget);
    int n = 0;
    while (grant != g && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(grant), 64'(g));
  endtask

  task automatic engine_clear();
    for (int p = 0; p < PORTS; p++) begin
      act[p] = 0; beat_idx[p] = 0; nbeats[p] = 1; cyc_rem[p] = 0;
      base_adr[p] = '0; base_dat[p] = '0; base_sel[p] = '0; base_we[p] = 1'b0;
      m_adr[p] = '0; m_dat[p] = '0; m_sel[p] = '0;
    end
    m_cyc = '0; m_stb = '0; m_we = '0;
    q0.delete();
    q1.delete();
    s_wb_ack_i = 1'b0;
    wait_cnt = 0;
  endtask

  initial begin
    int n;
    int stb_cnt;
    engine_clear();
    s_wb_err_i = 1'b0;
    s_wb_dat_i = 32'h1234_5678;
    rst = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_scyc", 64'(s_wb_cyc_o), 64'd0);
    check("rst_sstb", 64'(s_wb_stb_o), 64'd0);
    check("rst_swe", 64'(s_wb_we_o), 64'd0);
    check("rst_sadr", 64'(s_wb_adr_o), 64'd0);
    check("rst_sdat", 64'(s_wb_dat_o), 64'd0);
    check("rst_ssel", 64'(s_wb_sel_o), 64'd0);
    check("rst_mack", 64'(m_wb_ack_o), 64'd0);
    check("rst_merr", 64'(m_wb_err_o), 64'd0);
    check("rst_rdat", 64'(m_wb_dat_o), 64'h1234_5678);
    s_wb_dat_i = 32'hA5A5_0F0F;
    #1;
    check("rst_rdat2", 64'(m_wb_dat_o), 64'hA5A5_0F0F);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single read from master 0, slave acks after 2 cycles
    auto_m = 1; slave_mode = 0; ack_delay = 2;
    set_req(0, 36'h0_0000_0010, 32'h0, 4'hF, 1'b0, 1, 1);
    @(negedge clk);
    check("t1_grant_pre", 64'(grant), 64'd0);
    @(negedge clk);
    check("t1_grant", 64'(grant), 64'h1);
    check("t1_sadr", 64'(s_wb_adr_o), 64'h10);
    check("t1_scyc", 64'(s_wb_cyc_o), 64'd1);
    wait_idle("t1_done", 50);
    check("t1_q0_empty", 64'(q0.size()), 64'd0);

    // Master 1 writes while master 0 strobes
    ack_delay = 3;
    set_req(1, 36'h0_0000_0200, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1, 1);
    wait_grant("t3_grant1", 2'b10, 20);
    set_req(0, 36'h0_0000_0300, 32'h0, 4'hF, 1'b0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_grant_held", 64'(grant), 64'h2);
      check("t3_ssel", 64'(s_wb_sel_o), 64'h3);
      check("t3_sdat", 64'(s_wb_dat_o), 64'hDEAD_BEEF);
      check("t3_m0_no_ack", 64'(m_wb_ack_o[0]), 64'd0);
    end
    wait_idle("t3_done", 60);
    check("t3_q_empty", 64'(q0.size() + q1.size()), 64'd0);

    // Watchdog abort with TIMEOUT=8
    auto_m = 0; slave_mode = 1;
    @(posedge clk); #1;
    m_adr[0] = 36'h0_0000_0400; m_dat[0] = 32'h0; m_sel[0] = 4'hF; m_we[0] = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    n = 0; stb_cnt = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (m_wb_err_o[0]) break;
      if (s_wb_cyc_o && s_wb_stb_o) stb_cnt++;
    end
    $display("timeout err=%b stb_cycles=%0d", m_wb_err_o, stb_cnt);
    check("to_err", 64'(m_wb_err_o), 64'h1);
    check("to_stb_cycles", 64'(stb_cnt), 64'd8);
    check("to_pulse", 64'(timeout), 64'd1);
    check("to_stb_off", 64'(s_wb_stb_o), 64'd0);
    check("to_cyc_off", 64'(s_wb_cyc_o), 64'd0);
    @(posedge clk); #1;
    slave_mode = 2;
    @(negedge clk);
    check("to_pulse_end", 64'(timeout), 64'd0);
    check("to_err_end", 64'(m_wb_err_o), 64'd0);
    check("to_late_ack", 64'(m_wb_ack_o), 64'd0);
    check("to_abort_stb", 64'(s_wb_stb_o), 64'd0);
    @(posedge clk); #1;
    slave_mode = 1;
    m_stb[0] = 1'b0;
    @(negedge clk);
    check("to_abort_hold", 64'(s_wb_cyc_o), 64'd0);
    @(negedge clk);
    check("to_regrant_cyc", 64'(s_wb_cyc_o), 64'd1);
    check("to_regrant_stb", 64'(s_wb_stb_o), 64'd0);
    check("to_regrant_grant", 64'(grant), 64'h1);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0;
    wait_idle("to_done", 20);

    // Reset mid-transfer while master 1 holds the bus
    engine_clear();
    auto_m = 1;
    set_req(1, 36'h0_0000_0500, 32'hCAFE_0000, 4'hF, 1'b1, 1, 1);
    wait_grant("rs_grant1", 2'b10, 20);
    check("rs_scyc_pre", 64'(s_wb_cyc_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rs_scyc_async", 64'(s_wb_cyc_o), 64'd0);
    check("rs_grant_async", 64'(grant), 64'd0);
    check("rs_sstb_async", 64'(s_wb_stb_o), 64'd0);
    engine_clear();
    slave_mode = 0;
    ack_delay = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    glog.delete();

    // Both masters: two 3-beat cycles each, grants must alternate from master 0
    set_req(0, 36'h0_0000_1000, 32'h1111_0000, 4'hF, 1'b0, 2, 3);
    set_req(1, 36'h0_0000_2000, 32'h2222_0000, 4'hC, 1'b1, 2, 3);
    wait_idle("t2_done", 200);
    check("t2_grant_count", 64'(glog.size()), 64'd4);
    if (glog.size() >= 4) begin
      check("t2_grant0", 64'(glog[0]), 64'h1);
      check("t2_grant1", 64'(glog[1]), 64'h2);
      check("t2_grant2", 64'(glog[2]), 64'h1);
      check("t2_grant3", 64'(glog[3]), 64'h2);
    end
    check("t2_q_empty", 64'(q0.size() + q1.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
